// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg
// Shared raster timing definitions for the LCD/MTL panel path.
//   - default 800x480 timing constants
//   - timing_t    : one axis described as active / front porch / sync / back porch
//   - axis_geom_t : derived total length and active start of one axis
//   - axis_geom() : computes axis_geom_t from a timing_t
package lcd_timing_pkg;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 13;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 29;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } timing_t;

    typedef struct packed {
        logic [31:0] total;
        logic [31:0] start;
    } axis_geom_t;

    // Layout along an axis: sync, back porch, active, front porch.
    function automatic axis_geom_t axis_geom(input timing_t t);
        axis_geom_t g;
        g.start = 32'(t.sync) + 32'(t.bp);
        g.total = g.start + 32'(t.active) + 32'(t.fp);
        return g;
    endfunction

endpackage

// File: rtl/lcd_timing_gen_axis_counter.sv
// axis_counter
// Free-running modulo-TOTAL counter for one raster axis.
// Ports:
//   iCLK      : pixel clock
//   iRST_n    : asynchronous reset, active low
//   iEN       : advance enable; low holds the count
//   count     : current position, 0..TOTAL-1
//   wrap_next : high while count is TOTAL-1, i.e. the next enabled edge wraps
module axis_counter #(
    parameter int WIDTH = 11,
    parameter int TOTAL = 1056
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic             iEN,
    output logic [WIDTH-1:0] count,
    output logic             wrap_next
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);

    assign wrap_next = (count == LAST);

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n)
            count <= '0;
        else if (iEN)
            count <= wrap_next ? '0 : count + WIDTH'(1);
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen
// Parametrised raster timing generator: horizontal/vertical counters, sync
// pulses with programmable polarity, data enable, active-area coordinates and
// line/frame markers. Every output is decoded from the counters' next state
// and registered, so all outputs describe the current x_cnt/y_cnt.
// Ports:
//   iCLK, iRST_n (async, active low), iEN (low freezes all state)
//   x_cnt, y_cnt         : raster position
//   oHS, oVS             : sync pulses (active level HS_POL / VS_POL)
//   oDE                  : high inside the active area
//   oX, oY               : active-area column/row, 0 outside active
//   oLINE_START          : one cycle at x=0 after an x wrap
//   oFRAME_START         : one cycle at (0,0) after a frame wrap
//   oLAST_PIXEL          : high at (H_TOTAL-1, V_TOTAL-1)
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int XW       = 11,
    parameter int YW       = 10
) (
    input  logic          iCLK,
    input  logic          iRST_n,
    input  logic          iEN,
    output logic [XW-1:0] x_cnt,
    output logic [YW-1:0] y_cnt,
    output logic          oHS,
    output logic          oVS,
    output logic          oDE,
    output logic [XW-1:0] oX,
    output logic [YW-1:0] oY,
    output logic          oLINE_START,
    output logic          oFRAME_START,
    output logic          oLAST_PIXEL
);

    localparam timing_t    H_TIM  = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
    localparam timing_t    V_TIM  = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};
    localparam axis_geom_t H_GEOM = axis_geom(H_TIM);
    localparam axis_geom_t V_GEOM = axis_geom(V_TIM);

    localparam int H_TOTAL = int'(H_GEOM.total);
    localparam int H_START = int'(H_GEOM.start);
    localparam int V_TOTAL = int'(V_GEOM.total);
    localparam int V_START = int'(V_GEOM.start);

    generate
        if (H_TOTAL > 2**XW) begin : g_bad_h_total
            $error("lcd_timing_gen: H_TOTAL does not fit in XW bits");
        end
        if (V_TOTAL > 2**YW) begin : g_bad_v_total
            $error("lcd_timing_gen: V_TOTAL does not fit in YW bits");
        end
        if (H_ACTIVE == 0 || H_SYNC == 0 || V_ACTIVE == 0 || V_SYNC == 0) begin : g_bad_zero
            $error("lcd_timing_gen: ACTIVE and SYNC parameters must be non-zero");
        end
    endgenerate

    // Sized copies of the boundaries; the last active position is used rather
    // than an exclusive end, which could be 2**XW and overflow the width.
    localparam logic [XW-1:0] H_SYNC_C  = XW'(H_SYNC);
    localparam logic [XW-1:0] H_START_C = XW'(H_START);
    localparam logic [XW-1:0] H_ALAST_C = XW'(H_START + H_ACTIVE - 1);
    localparam logic [XW-1:0] H_LAST_C  = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_SYNC_C  = YW'(V_SYNC);
    localparam logic [YW-1:0] V_START_C = YW'(V_START);
    localparam logic [YW-1:0] V_ALAST_C = YW'(V_START + V_ACTIVE - 1);
    localparam logic [YW-1:0] V_LAST_C  = YW'(V_TOTAL - 1);

    logic x_wrap;
    logic y_wrap;

    axis_counter #(.WIDTH(XW), .TOTAL(H_TOTAL)) u_x_cnt (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .iEN       (iEN),
        .count     (x_cnt),
        .wrap_next (x_wrap)
    );

    axis_counter #(.WIDTH(YW), .TOTAL(V_TOTAL)) u_y_cnt (
        .iCLK      (iCLK),
        .iRST_n    (iRST_n),
        .iEN       (iEN & x_wrap),
        .count     (y_cnt),
        .wrap_next (y_wrap)
    );

    // Next-state counters, mirroring the axis_counter update rule, so the
    // registered decode lands in the same cycle as the new count.
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;

    always_comb begin
        x_nxt = x_wrap ? '0 : x_cnt + XW'(1);
        y_nxt = y_cnt;
        if (x_wrap)
            y_nxt = y_wrap ? '0 : y_cnt + YW'(1);
    end

    logic          hs_d, vs_d, de_d, lp_d;
    logic          h_act, v_act;
    logic [XW-1:0] ox_d;
    logic [YW-1:0] oy_d;

    always_comb begin
        h_act = (x_nxt >= H_START_C) && (x_nxt <= H_ALAST_C);
        v_act = (y_nxt >= V_START_C) && (y_nxt <= V_ALAST_C);
        de_d  = h_act && v_act;
        hs_d  = (x_nxt < H_SYNC_C) ? HS_POL : ~HS_POL;
        vs_d  = (y_nxt < V_SYNC_C) ? VS_POL : ~VS_POL;
        ox_d  = de_d ? x_nxt - H_START_C : '0;
        oy_d  = de_d ? y_nxt - V_START_C : '0;
        lp_d  = (x_nxt == H_LAST_C) && (y_nxt == V_LAST_C);
    end

    // Reset values equal the decode of (0,0) with no markers; the first
    // frame after reset therefore carries no oFRAME_START.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oHS          <= HS_POL;
            oVS          <= VS_POL;
            oDE          <= 1'b0;
            oX           <= '0;
            oY           <= '0;
            oLINE_START  <= 1'b0;
            oFRAME_START <= 1'b0;
            oLAST_PIXEL  <= 1'b0;
        end else if (iEN) begin
            oHS          <= hs_d;
            oVS          <= vs_d;
            oDE          <= de_d;
            oX           <= ox_d;
            oY           <= oy_d;
            oLINE_START  <= x_wrap;
            oFRAME_START <= x_wrap & y_wrap;
            oLAST_PIXEL  <= lp_d;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen
// Directed, table-driven check of lcd_timing_gen on a tiny 8x6 raster
// (H: sync 0..1, bp 2, active 3..6, fp 7; V: sync 0, bp 1, active 2..4, fp 5).
// A second instance with inverted sync polarity runs in lock-step.
module tb_lcd_timing_gen;

    localparam int XW = 11;
    localparam int YW = 10;

    logic          iCLK = 1'b0;
    logic          iRST_n = 1'b0;
    logic          iEN = 1'b0;
    logic [XW-1:0] x_cnt, oX, x_cnt2, oX2;
    logic [YW-1:0] y_cnt, oY, y_cnt2, oY2;
    logic          oHS, oVS, oDE, oLINE_START, oFRAME_START, oLAST_PIXEL;
    logic          oHS2, oVS2, oDE2, oLINE_START2, oFRAME_START2, oLAST_PIXEL2;

    always #5 iCLK = ~iCLK;

    lcd_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .XW(XW), .YW(YW)
    ) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iEN(iEN),
        .x_cnt(x_cnt), .y_cnt(y_cnt), .oHS(oHS), .oVS(oVS), .oDE(oDE),
        .oX(oX), .oY(oY), .oLINE_START(oLINE_START),
        .oFRAME_START(oFRAME_START), .oLAST_PIXEL(oLAST_PIXEL)
    );

    lcd_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .XW(XW), .YW(YW)
    ) dut_pol (
        .iCLK(iCLK), .iRST_n(iRST_n), .iEN(iEN),
        .x_cnt(x_cnt2), .y_cnt(y_cnt2), .oHS(oHS2), .oVS(oVS2), .oDE(oDE2),
        .oX(oX2), .oY(oY2), .oLINE_START(oLINE_START2),
        .oFRAME_START(oFRAME_START2), .oLAST_PIXEL(oLAST_PIXEL2)
    );

    typedef struct {
        int n;     // clocks to run
        bit en;    // iEN during those clocks
        int x, y;
        bit hs, vs, de;
        int ox, oy;
        bit ls, fs, lp;
    } vec_t;

    vec_t tbl[21];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".x"},   int'(x_cnt), v.x);
        chk({tag, ".y"},   int'(y_cnt), v.y);
        chk({tag, ".hs"},  int'(oHS), int'(v.hs));
        chk({tag, ".vs"},  int'(oVS), int'(v.vs));
        chk({tag, ".de"},  int'(oDE), int'(v.de));
        chk({tag, ".ox"},  int'(oX), v.ox);
        chk({tag, ".oy"},  int'(oY), v.oy);
        chk({tag, ".ls"},  int'(oLINE_START), int'(v.ls));
        chk({tag, ".fs"},  int'(oFRAME_START), int'(v.fs));
        chk({tag, ".lp"},  int'(oLAST_PIXEL), int'(v.lp));
        chk({tag, ".hs_pol1"}, int'(oHS2), int'(!v.hs));
        chk({tag, ".vs_pol1"}, int'(oVS2), int'(!v.vs));
    endtask

    initial begin
        vec_t rv;
        //            n  en  x  y hs vs de ox oy ls fs lp
        tbl[0]  = '{ 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}; // held after reset
        tbl[1]  = '{ 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{ 1, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{ 5, 1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{ 1, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0}; // line wrap
        tbl[5]  = '{ 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{10, 1, 3, 2, 1, 1, 1, 0, 0, 0, 0, 0}; // first active pixel
        tbl[7]  = '{ 3, 1, 6, 2, 1, 1, 1, 3, 0, 0, 0, 0}; // last active pixel
        tbl[8]  = '{ 1, 1, 7, 2, 1, 1, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{13, 1, 4, 4, 1, 1, 1, 1, 2, 0, 0, 0};
        tbl[10] = '{ 7, 1, 3, 5, 1, 1, 0, 0, 0, 0, 0, 0}; // front-porch line
        tbl[11] = '{ 4, 1, 7, 5, 1, 1, 0, 0, 0, 0, 0, 1}; // last pixel
        tbl[12] = '{ 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0}; // frame wrap
        tbl[13] = '{ 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[14] = '{ 8, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[15] = '{19, 1, 4, 3, 1, 1, 1, 1, 1, 0, 0, 0}; // stall point
        tbl[16] = '{ 3, 0, 4, 3, 1, 1, 1, 1, 1, 0, 0, 0}; // frozen
        tbl[17] = '{ 1, 1, 5, 3, 1, 1, 1, 2, 1, 0, 0, 0}; // resume
        tbl[18] = '{ 3, 1, 0, 4, 0, 1, 0, 0, 0, 1, 0, 0};
        tbl[19] = '{ 2, 0, 0, 4, 0, 1, 0, 0, 0, 1, 0, 0}; // pulse held by stall
        tbl[20] = '{ 1, 1, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0};

        // Reset: outputs already at reset state while iRST_n is low.
        repeat (2) @(negedge iCLK);
        rv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        chk_all("reset", rv);
        iRST_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            iEN = tbl[i].en;
            repeat (tbl[i].n) @(negedge iCLK);
            chk_all($sformatf("v%0d", i), tbl[i]);
        end

        // Run to x=5,y=3 of the next frame (t=81 -> t=125), then pull reset
        // between edges and check the outputs drop without a clock.
        iEN = 1'b1;
        repeat (44) @(negedge iCLK);
        chk("mid.x", int'(x_cnt), 5);
        chk("mid.y", int'(y_cnt), 3);
        chk("mid.de", int'(oDE), 1);
        #2 iRST_n = 1'b0;
        #1 chk_all("async_rst", rv);
        @(negedge iCLK);
        chk_all("rst_held_en1", rv);
        iRST_n = 1'b1;
        @(negedge iCLK);
        rv.x = 1;
        chk_all("after_rst", rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Parametrised raster timing generator for the LCD/MTL panel path; successor to the plain X/Y line counter.
- Produces horizontal and vertical counters, sync pulses with programmable polarity, a data-enable signal, active-area pixel coordinates and frame/line markers.
- Feeds the pixel/line-drawing logic and the panel pins; all outputs are registered and aligned to the current counter values.

Parameters:
- H_ACTIVE, 800, active pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, horizontal sync width
- H_BP, 88, horizontal back porch
- V_ACTIVE, 480, active lines per frame
- V_FP, 13, vertical front porch (lines)
- V_SYNC, 3, vertical sync width
- V_BP, 29, vertical back porch
- HS_POL, 0, active level of oHS
- VS_POL, 0, active level of oVS
- XW, 11, horizontal counter width
- YW, 10, vertical counter width

Ports:
- iCLK  in  1  pixel clock
- iRST_n  in  1  asynchronous reset, active low
- iEN  in  1  advance enable; low = freeze all state
- x_cnt  out  XW  horizontal position, 0..H_TOTAL-1
- y_cnt  out  YW  vertical position, 0..V_TOTAL-1
- oHS  out  1  horizontal sync
- oVS  out  1  vertical sync
- oDE  out  1  data enable (active area)
- oX  out  XW  active-area column, 0 outside active
- oY  out  YW  active-area row, 0 outside active
- oLINE_START  out  1  one-cycle pulse at x_cnt wrap to 0
- oFRAME_START  out  1  one-cycle pulse at (0,0) after frame wrap
- oLAST_PIXEL  out  1  high while x_cnt=H_TOTAL-1 and y_cnt=V_TOTAL-1

Behaviour:
- Derived constants:
  - H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP
  - H_START = H_SYNC+H_BP
  - V_TOTAL and V_START defined the same way.
  - Line layout: sync [0,H_SYNC), back porch, active [H_START, H_START+H_ACTIVE), front porch. Frame layout is identical, counted in lines.
- Elaboration $error if H_TOTAL > 2**XW, V_TOTAL > 2**YW, or any ACTIVE/SYNC parameter is 0.
- Reset (asynchronous, active-low): x_cnt=0, y_cnt=0, oHS=HS_POL, oVS=VS_POL, oDE=0, oX=0, oY=0, oLINE_START=0, oFRAME_START=0, oLAST_PIXEL=0. These are the decode of (0,0) with no pulses.
- Per iCLK edge with iEN=1:
  - x_cnt increments, wrapping H_TOTAL-1 -> 0.
  - On that wrap, y_cnt increments, wrapping V_TOTAL-1 -> 0.
  - With iEN=0, every register, pulses included, holds its value.
- Output alignment: outputs are decoded from next-state counters and registered, so every output in a cycle describes that cycle's x_cnt/y_cnt. There is zero cycles of latency relative to the counters.
- oHS: HS_POL while x_cnt < H_SYNC, else ~HS_POL.
- oVS: VS_POL while y_cnt < V_SYNC, else ~VS_POL. oVS is line-granular and changes only together with an x wrap.
- oDE: 1 iff x_cnt is in the horizontal active range and y_cnt is in the vertical active range.
- oX = x_cnt-H_START and oY = y_cnt-V_START when oDE=1, otherwise 0.
- oLINE_START: 1 for exactly the cycle in which x_cnt=0 following an enabled wrap. It stays 1 if iEN drops in that cycle, because state holds.
- oFRAME_START: same rule, for the wrap of both counters. It is not asserted after reset; the first frame after reset has no marker.
- Mid-operation reset returns to the reset state immediately, independent of iEN.

Decomposition:
- Package lcd_timing_pkg holds:
  - the default 800x480 timing constants;
  - a timing_t struct (active/fp/sync/bp);
  - a function computing total and start from a timing_t.
- One sub-module, axis_counter (params WIDTH, TOTAL). Ports: iCLK, iRST_n, iEN, count, wrap_next. Instantiated twice: the x instance enabled by iEN, the y instance by iEN & x wrap_next.

Test Plan:
Test parameters: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8, H_START=3); V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6, V_START=2); POL=0.
1. Reset and hold: iRST_n low, then high with iEN=0 for 5 cycles -> x=0, y=0, oHS=0, oVS=0, oDE=0, no pulses throughout.
2. Line 0 free-run with iEN=1 -> oHS=0 at x=0..1 and 1 at x=2..7. oDE=0 on the whole line (y=0). At x=7->0, y=1 and oLINE_START=1 for one cycle.
3. Active line y=2 -> oDE=1 exactly at x=3..6 with oX=0..3, oY=0. At y=4, oY=2. At y=5, oDE=0.
4. Frame wrap after 48 enabled cycles -> oLAST_PIXEL=1 at (7,5), then (0,0) with oFRAME_START=1 for one cycle and oVS=0. oVS=1 from y=1 onward.
5. Stall iEN=0 for 3 cycles at x=4, y=3 -> all outputs frozen (oDE=1, oX=1). Resume continues with x=5, oX=2.
6. Assert iRST_n low mid-line at x=5, y=3 -> outputs take reset values asynchronously, before the next edge. HS_POL=1 variant: oHS=1 at x=0..1.
